// File: rtl/axi4_lite_defs_pkg.sv
// Shared AXI4-Lite definitions: response codes, byte-address LSB and the
// write/read FSM state encodings. The response codes are also consumed by
// the master wrapper, so they live here rather than in the slave.
package axi4_lite_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Registers are word-addressed; the two byte-offset bits are ignored.
  localparam int unsigned ADDR_LSB = 2;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

endpackage

// File: rtl/axi4_lite_regfile_core.sv
// Register bank for the AXI4-Lite slave.
//   clk, rst  : rising-edge clock, synchronous active-high clear of all registers
//   wr_en     : commit strobe; wr_idx/wr_data/wr_strb select register and bytes
//   rd_idx    : combinational read index, rd_data returns the current contents
//   regs      : flattened contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
module axi4_lite_regfile_core #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned b = 0; b < NUM_BYTES; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read is combinational from the array, so a read sampled on the same edge
  // as a write commit sees the pre-write value.
  assign rd_data = mem[rd_idx];

  always_comb begin
    regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave terminating a register file of NUM_REGS 32-bit registers.
//   iCLK, iRST        : rising-edge clock, synchronous active-high reset
//   s_AW*/s_W*/s_B*   : write address, write data and write response channels
//   s_AR*/s_R*        : read address and read data channels
//   o_REGS            : flattened register contents, reg i at [i*DW +: DW]
// Out-of-range addresses (any bit above the index field set) answer SLVERR;
// such writes change nothing and such reads return zero.
module axi4_lite_slave_regfile
  import axi4_lite_defs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           iCLK,
  input  logic                           iRST,
  input  logic                           s_AWVALID,
  output logic                           s_AWREADY,
  input  logic [ADDR_WIDTH-1:0]          s_AWADDR,
  input  logic [2:0]                     s_AWPROT,
  input  logic                           s_WVALID,
  output logic                           s_WREADY,
  input  logic [DATA_WIDTH-1:0]          s_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        s_WSTRB,
  output logic                           s_BVALID,
  input  logic                           s_BREADY,
  output logic [1:0]                     s_BRESP,
  input  logic                           s_ARVALID,
  output logic                           s_ARREADY,
  input  logic [ADDR_WIDTH-1:0]          s_ARADDR,
  input  logic [2:0]                     s_ARPROT,
  output logic                           s_RVALID,
  input  logic                           s_RREADY,
  output logic [DATA_WIDTH-1:0]          s_RDATA,
  output logic [1:0]                     s_RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_REGS
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int HI_LSB = ADDR_LSB + IDX_W;

  wstate_t wstate;
  rstate_t rstate;

  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;

  logic aw_hs, w_hs, ar_hs;
  logic commit;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_data;
  logic [DATA_WIDTH/8-1:0] c_strb;
  logic                    c_ok, ar_ok;
  logic [DATA_WIDTH-1:0]   core_rd;

  logic unused_prot;
  assign unused_prot = ^{s_AWPROT, s_ARPROT};

  // Ready outputs follow state but are forced low while reset is asserted.
  assign s_AWREADY = !iRST && (wstate == W_IDLE || wstate == W_HAVE_DATA);
  assign s_WREADY  = !iRST && (wstate == W_IDLE || wstate == W_HAVE_ADDR);
  assign s_ARREADY = !iRST && (rstate == R_IDLE);

  assign aw_hs = s_AWVALID && s_AWREADY;
  assign w_hs  = s_WVALID  && s_WREADY;
  assign ar_hs = s_ARVALID && s_ARREADY;

  // Commit happens on the later of the two handshakes; the earlier one's
  // payload comes from the latch, the later one's straight from the bus.
  always_comb begin
    commit = 1'b0;
    c_addr = s_AWADDR;
    c_data = s_WDATA;
    c_strb = s_WSTRB;
    unique case (wstate)
      W_IDLE:      commit = aw_hs && w_hs;
      W_HAVE_ADDR: begin
        commit = w_hs;
        c_addr = aw_addr_q;
      end
      W_HAVE_DATA: begin
        commit = aw_hs;
        c_data = w_data_q;
        c_strb = w_strb_q;
      end
      W_RESP:      commit = 1'b0;
      default:     commit = 1'b0;
    endcase
  end

  assign c_ok  = (c_addr   >> HI_LSB) == '0;
  assign ar_ok = (s_ARADDR >> HI_LSB) == '0;

  axi4_lite_regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_core (
    .clk     (iCLK),
    .rst     (iRST),
    .wr_en   (commit && c_ok),
    .wr_idx  (c_addr[HI_LSB-1:ADDR_LSB]),
    .wr_data (c_data),
    .wr_strb (c_strb),
    .rd_idx  (s_ARADDR[HI_LSB-1:ADDR_LSB]),
    .rd_data (core_rd),
    .regs    (o_REGS)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wstate    <= W_IDLE;
      s_BVALID  <= 1'b0;
      s_BRESP   <= RESP_OKAY;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      wstate   <= W_RESP;
      s_BVALID <= 1'b1;
      s_BRESP  <= c_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= s_AWADDR;
            wstate    <= W_HAVE_ADDR;
          end else if (w_hs) begin
            w_data_q <= s_WDATA;
            w_strb_q <= s_WSTRB;
            wstate   <= W_HAVE_DATA;
          end
        end
        W_HAVE_ADDR, W_HAVE_DATA: wstate <= wstate;
        W_RESP: begin
          if (s_BREADY) begin
            s_BVALID <= 1'b0;
            wstate   <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rstate   <= R_IDLE;
      s_RVALID <= 1'b0;
      s_RDATA  <= '0;
      s_RRESP  <= RESP_OKAY;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            s_RDATA  <= ar_ok ? core_rd : '0;
            s_RRESP  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            s_RVALID <= 1'b1;
            rstate   <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_RREADY) begin
            s_RVALID <= 1'b0;
            rstate   <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
module tb_axi4_lite_slave_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rvalid, rready;
  logic [AW-1:0]  awaddr, araddr;
  logic [2:0]     awprot, arprot;
  logic [DW-1:0]  wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]     bresp, rresp;
  logic [NR*DW-1:0] regs;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [NR];

  axi4_lite_slave_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .s_AWVALID (awvalid),
    .s_AWREADY (awready),
    .s_AWADDR  (awaddr),
    .s_AWPROT  (awprot),
    .s_WVALID  (wvalid),
    .s_WREADY  (wready),
    .s_WDATA   (wdata),
    .s_WSTRB   (wstrb),
    .s_BVALID  (bvalid),
    .s_BREADY  (bready),
    .s_BRESP   (bresp),
    .s_ARVALID (arvalid),
    .s_ARREADY (arready),
    .s_ARADDR  (araddr),
    .s_ARPROT  (arprot),
    .s_RVALID  (rvalid),
    .s_RREADY  (rready),
    .s_RDATA   (rdata),
    .s_RRESP   (rresp),
    .o_REGS    (regs)
  );

  function automatic logic [NR*DW-1:0] model_vec();
    logic [NR*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    awvalid = 0; awaddr = '0; awprot = '0;
    wvalid = 0; wdata = '0; wstrb = '0;
    arvalid = 0; araddr = '0; arprot = '0;
    bready = 0; rready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    checks++; if (awready !== 1'b0) begin errors++; $display("FAIL reset_awready: got %b want 0", awready); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b want 0", wready); end
    checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %b want 0", arready); end
    checks++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin errors++; $display("FAIL reset_valids: bvalid %b rvalid %b want 0 0", bvalid, rvalid); end
    checks++; if (rdata !== '0 || bresp !== 2'b00 || rresp !== 2'b00) begin errors++; $display("FAIL reset_resp: rdata %h bresp %b rresp %b want 0", rdata, bresp, rresp); end
    checks++; if (regs !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", regs); end
    for (int i = 0; i < NR; i++) model[i] = '0;
    rst = 0;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL post_reset_ready: got %b want 111", {awready, wready, arready}); end
  endtask

  task automatic test_basic_write_read();
    awvalid = 1; awaddr = 32'h08; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1;
    tick();
    awvalid = 0; wvalid = 0;
    model[2] = 32'hDEADBEEF;
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL basic_bresp: bvalid %b bresp %b want 1 00", bvalid, bresp); end
    checks++; if (regs !== model_vec()) begin errors++; $display("FAIL basic_regs: got %h want %h", regs, model_vec()); end
    checks++; if (awready !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL basic_resp_ready: aw %b w %b want 0 0", awready, wready); end
    tick();
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL basic_bdone: got %b want 0", bvalid); end
    arvalid = 1; araddr = 32'h08; rready = 1;
    tick();
    arvalid = 0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin errors++; $display("FAIL basic_read: rvalid %b rdata %h rresp %b want 1 deadbeef 00", rvalid, rdata, rresp); end
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL basic_rdone: got %b want 0", rvalid); end
    bready = 0; rready = 0;
  endtask

  task automatic test_w_leads_aw();
    bready = 1;
    wvalid = 1; wdata = 32'h11223344; wstrb = 4'b0101;
    tick();
    wvalid = 0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin errors++; $display("FAIL have_data_ready[%0d]: w %b aw %b b %b want 0 1 0", c, wready, awready, bvalid); end
      if (c < 2) tick();
    end
    awvalid = 1; awaddr = 32'h08;
    tick();
    awvalid = 0;
    model[2] = 32'hDE22BE44;
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL wlead_bresp: bvalid %b bresp %b want 1 00", bvalid, bresp); end
    checks++; if (regs[2*DW +: DW] !== 32'hDE22BE44) begin errors++; $display("FAIL wlead_reg2: got %h want de22be44", regs[2*DW +: DW]); end
    tick();
    bready = 0;
  endtask

  task automatic test_backpressure();
    awvalid = 1; awaddr = 32'h0C; wvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; bready = 0;
    tick();
    model[3] = 32'hA5A5A5A5;
    awaddr = 32'h10; wdata = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      checks++; if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: b %b resp %b aw %b w %b want 1 00 0 0", c, bvalid, bresp, awready, wready); end
      checks++; if (regs !== model_vec()) begin errors++; $display("FAIL bp_regs[%0d]: got %h want %h", c, regs, model_vec()); end
      tick();
    end
    awvalid = 0; wvalid = 0; bready = 1;
    tick();
    checks++; if (bvalid !== 1'b0 || regs !== model_vec()) begin errors++; $display("FAIL bp_release: bvalid %b regs %h want 0 %h", bvalid, regs, model_vec()); end
    bready = 0;
    arvalid = 1; araddr = 32'h0C; rready = 0;
    tick();
    arvalid = 0;
    for (int c = 0; c < 4; c++) begin
      checks++; if (rvalid !== 1'b1 || rdata !== 32'hA5A5A5A5 || rresp !== 2'b00 || arready !== 1'b0) begin errors++; $display("FAIL rbp_hold[%0d]: rv %b rdata %h rresp %b ar %b want 1 a5a5a5a5 00 0", c, rvalid, rdata, rresp, arready); end
      tick();
    end
    rready = 1;
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rbp_release: got %b want 0", rvalid); end
    rready = 0;
  endtask

  task automatic test_out_of_range();
    bready = 1; rready = 1;
    awvalid = 1; awaddr = 32'h40; wvalid = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    checks++; if (bvalid !== 1'b1 || bresp !== 2'b10) begin errors++; $display("FAIL oor_bresp: bvalid %b bresp %b want 1 10", bvalid, bresp); end
    checks++; if (regs !== model_vec()) begin errors++; $display("FAIL oor_regs: got %h want %h", regs, model_vec()); end
    tick();
    // Highest valid word with low byte-offset bits set.
    awvalid = 1; awaddr = 32'h3F; wvalid = 1; wdata = 32'h000000FF; wstrb = 4'b0001;
    tick();
    awvalid = 0; wvalid = 0;
    model[15] = 32'h000000FF;
    checks++; if (bresp !== 2'b00 || regs !== model_vec()) begin errors++; $display("FAIL top_reg_write: bresp %b regs %h want 00 %h", bresp, regs, model_vec()); end
    tick();
    wvalid = 1; awvalid = 1; awaddr = 32'h08; wdata = 32'h12345678; wstrb = 4'h0;
    tick();
    awvalid = 0; wvalid = 0;
    checks++; if (bresp !== 2'b00 || regs !== model_vec()) begin errors++; $display("FAIL zero_strb: bresp %b regs %h want 00 %h", bresp, regs, model_vec()); end
    tick();
    arvalid = 1; araddr = 32'h1000;
    tick();
    arvalid = 0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b10) begin errors++; $display("FAIL oor_read: rv %b rdata %h rresp %b want 1 0 10", rvalid, rdata, rresp); end
    tick();
    arvalid = 1; araddr = 32'h3C;
    tick();
    arvalid = 0;
    checks++; if (rdata !== 32'h000000FF || rresp !== 2'b00) begin errors++; $display("FAIL top_reg_read: rdata %h rresp %b want 000000ff 00", rdata, rresp); end
    tick();
    bready = 0; rready = 0;
  endtask

  task automatic test_back_to_back();
    bready = 1;
    awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h11111111; wstrb = 4'hF;
    tick();
    model[5] = 32'h11111111;
    checks++; if (bvalid !== 1'b1 || regs !== model_vec()) begin errors++; $display("FAIL b2b_first: bvalid %b regs %h want 1 %h", bvalid, regs, model_vec()); end
    awaddr = 32'h18; wdata = 32'h22222222;
    tick();
    checks++; if (bvalid !== 1'b0 || awready !== 1'b1 || regs !== model_vec()) begin errors++; $display("FAIL b2b_gap: bvalid %b aw %b regs %h want 0 1 %h", bvalid, awready, regs, model_vec()); end
    tick();
    awvalid = 0; wvalid = 0;
    model[6] = 32'h22222222;
    checks++; if (bvalid !== 1'b1 || regs !== model_vec()) begin errors++; $display("FAIL b2b_second: bvalid %b regs %h want 1 %h", bvalid, regs, model_vec()); end
    tick();
    bready = 0;
  endtask

  task automatic test_concurrent();
    bready = 1; rready = 1;
    awvalid = 1; awaddr = 32'h04; wvalid = 1; wdata = 32'h00000005; wstrb = 4'hF;
    arvalid = 1; araddr = 32'h04;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL concur_old: rv %b rdata %h want 1 0", rvalid, rdata); end
    model[1] = 32'h5;
    checks++; if (bvalid !== 1'b1 || regs !== model_vec()) begin errors++; $display("FAIL concur_write: bvalid %b regs %h want 1 %h", bvalid, regs, model_vec()); end
    tick();
    arvalid = 1;
    tick();
    arvalid = 0;
    checks++; if (rdata !== 32'h5) begin errors++; $display("FAIL concur_new: rdata %h want 5", rdata); end
    tick();
    bready = 0; rready = 0;
  endtask

  task automatic test_reset_mid();
    awvalid = 1; awaddr = 32'h00; wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF; bready = 0;
    tick();
    awvalid = 0; wvalid = 0;
    checks++; if (bvalid !== 1'b1 || regs[DW-1:0] !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_pre: bvalid %b reg0 %h want 1 cafef00d", bvalid, regs[DW-1:0]); end
    rst = 1;
    tick();
    checks++; if (bvalid !== 1'b0 || regs !== '0 || awready !== 1'b0) begin errors++; $display("FAIL mid_reset: bvalid %b regs %h aw %b want 0 0 0", bvalid, regs, awready); end
    rst = 0;
    #1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL mid_recover: got %b want 111", {awready, wready, arready}); end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_basic_write_read();
    test_w_leads_aw();
    test_backpressure();
    test_out_of_range();
    test_back_to_back();
    test_concurrent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
